// File: rtl/uart_baud_pkg.sv
// Shared constants and elaboration-time helpers for the fractional UART baud generator.
package uart_baud_pkg;

    localparam int unsigned DIV_W_DEF      = 16;
    localparam int unsigned FRAC_W_DEF     = 8;
    localparam int unsigned OVERSAMPLE_DEF = 16;

    function automatic int unsigned os_cnt_width(input int unsigned os);
        return (os < 2) ? 1 : $clog2(os);
    endfunction

    localparam int unsigned OS_CNT_W = os_cnt_width(OVERSAMPLE_DEF);

    // Fixed-point clk_freq / (baud * os) with frac_w fraction bits, rounded to nearest and
    // clamped to an integer part of at least 2.
    function automatic longint unsigned default_div(input longint unsigned clk_freq,
                                                    input longint unsigned baud,
                                                    input longint unsigned os,
                                                    input int unsigned     frac_w);
        longint unsigned rate;
        longint unsigned q;
        rate = baud * os;
        q    = ((clk_freq << frac_w) + rate / 2) / rate;
        if ((q >> frac_w) < 64'd2) begin
            q = 64'd2 << frac_w;
        end
        return q;
    endfunction

endpackage

// File: rtl/uart_frac_divider.sv
// Oversample-period divider: period counter, shadow divisor applied at period boundaries and,
// when UART_FRAC_DIV_EN is defined, a fractional accumulator stretching periods by one clk.
module uart_frac_divider #(
    parameter int unsigned      DivW    = 16,
    parameter int unsigned      FracW   = 8,
    parameter logic [DivW-1:0]  DefInt  = DivW'(2),
    parameter logic [FracW-1:0] DefFrac = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             div_load_i,
    input  logic [DivW-1:0]  div_int_i,
    input  logic [FracW-1:0] div_frac_i,
    output logic             period_end_o,
    output logic             os_tick_o
);

    localparam logic [DivW-1:0] MinInt = DivW'(2);

    logic [DivW-1:0] cnt_q, cnt_d;
    logic [DivW-1:0] act_int_q, act_int_d;
    logic [DivW-1:0] shd_int_q, shd_int_d;
    logic            pend_q, pend_d;
    logic            os_tick_q, os_tick_d;
    logic [DivW-1:0] load_int;
    logic [DivW:0]   cnt_inc;
    logic [DivW:0]   period_len;
    logic            carry;
    logic            period_end;
    logic            apply_now;

    assign load_int   = (div_int_i < MinInt) ? MinInt : div_int_i;
    assign cnt_inc    = {1'b0, cnt_q} + {{DivW{1'b0}}, 1'b1};
    assign period_len = {1'b0, act_int_q} + {{DivW{1'b0}}, carry};
    // >= so an immediate load of a shorter divisor while halted ends the period on resume
    assign period_end = en_i && !sync_i && (cnt_inc >= period_len);
    assign apply_now  = !en_i || sync_i || period_end;

    always_comb begin
        cnt_d     = cnt_q;
        act_int_d = act_int_q;
        shd_int_d = shd_int_q;
        pend_d    = pend_q;
        os_tick_d = 1'b0;
        if (sync_i) begin
            cnt_d = '0;
        end else if (period_end) begin
            cnt_d     = '0;
            os_tick_d = 1'b1;
        end else if (en_i) begin
            cnt_d = cnt_inc[DivW-1:0];
        end
        if (div_load_i) begin
            shd_int_d = load_int;
            if (apply_now) begin
                act_int_d = load_int;
                pend_d    = 1'b0;
            end else begin
                pend_d = 1'b1;
            end
        end else if (pend_q && period_end) begin
            act_int_d = shd_int_q;
            pend_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            act_int_q <= DefInt;
            shd_int_q <= DefInt;
            pend_q    <= 1'b0;
            os_tick_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            act_int_q <= act_int_d;
            shd_int_q <= shd_int_d;
            pend_q    <= pend_d;
            os_tick_q <= os_tick_d;
        end
    end

`ifdef UART_FRAC_DIV_EN
    logic [FracW-1:0] acc_q, acc_d;
    logic [FracW-1:0] act_frac_q, act_frac_d;
    logic [FracW-1:0] shd_frac_q, shd_frac_d;
    logic             carry_q, carry_d;

    assign carry = carry_q;

    // The ending period accumulates its own fraction; the carry lengthens the next period.
    always_comb begin
        acc_d      = acc_q;
        carry_d    = carry_q;
        act_frac_d = act_frac_q;
        shd_frac_d = shd_frac_q;
        if (sync_i) begin
            acc_d   = '0;
            carry_d = 1'b0;
        end else if (period_end) begin
            {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, act_frac_q};
        end
        if (div_load_i) begin
            shd_frac_d = div_frac_i;
            if (apply_now) begin
                act_frac_d = div_frac_i;
            end
        end else if (pend_q && period_end) begin
            act_frac_d = shd_frac_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q      <= '0;
            carry_q    <= 1'b0;
            act_frac_q <= DefFrac;
            shd_frac_q <= DefFrac;
        end else begin
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            act_frac_q <= act_frac_d;
            shd_frac_q <= shd_frac_d;
        end
    end
`else
    logic unused_frac;

    assign carry       = 1'b0;
    assign unused_frac = ^{div_frac_i, DefFrac};
`endif

    assign period_end_o = period_end;
    assign os_tick_o    = os_tick_q;

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Runtime-programmable UART baud generator: os_tick, baud_tick and UART_clk from a
// fractional divider. Fractional periods are built only when UART_FRAC_DIV_EN is defined.
module uart_baud_gen_frac
    import uart_baud_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 1_000_000_000 / 12,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int unsigned DIV_W      = DIV_W_DEF,
    parameter int unsigned FRAC_W     = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync,
    input  logic              div_load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              os_tick,
    output logic              baud_tick,
    output logic              UART_clk
);

    localparam longint unsigned DefDiv = default_div(64'(CLK_FREQ), 64'(BAUD),
                                                     64'(OVERSAMPLE), FRAC_W);
    localparam logic [DIV_W-1:0]  DefInt  = DIV_W'(DefDiv >> FRAC_W);
    localparam logic [FRAC_W-1:0] DefFrac = FRAC_W'(DefDiv);

    localparam int unsigned       OsCntW = os_cnt_width(OVERSAMPLE);
    localparam logic [OsCntW-1:0] OsLast = OsCntW'(OVERSAMPLE - 1);
    localparam logic [OsCntW-1:0] OsHalf = OsCntW'(OVERSAMPLE / 2 - 1);
    localparam logic [OsCntW-1:0] OsOne  = OsCntW'(1);

    if (OVERSAMPLE < 2 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("OVERSAMPLE must be even and at least 2");
    end

    logic              period_end;
    logic              os_tick_int;
    logic [OsCntW-1:0] os_cnt_q, os_cnt_d;
    logic              baud_tick_q, baud_tick_d;
    logic              uart_clk_q, uart_clk_d;

    uart_frac_divider #(
        .DivW    (DIV_W),
        .FracW   (FRAC_W),
        .DefInt  (DefInt),
        .DefFrac (DefFrac)
    ) u_divider (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .sync_i       (sync),
        .div_load_i   (div_load),
        .div_int_i    (div_int),
        .div_frac_i   (div_frac),
        .period_end_o (period_end),
        .os_tick_o    (os_tick_int)
    );

    // Decisions use the pre-increment os_cnt so baud_tick and UART_clk align with os_tick.
    always_comb begin
        os_cnt_d    = os_cnt_q;
        baud_tick_d = 1'b0;
        uart_clk_d  = uart_clk_q;
        if (sync) begin
            os_cnt_d   = '0;
            uart_clk_d = 1'b0;
        end else if (period_end) begin
            baud_tick_d = (os_cnt_q == OsLast);
            os_cnt_d    = baud_tick_d ? '0 : os_cnt_q + OsOne;
            if (os_cnt_q == OsHalf || os_cnt_q == OsLast) begin
                uart_clk_d = ~uart_clk_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            os_cnt_q    <= '0;
            baud_tick_q <= 1'b0;
            uart_clk_q  <= 1'b0;
        end else begin
            os_cnt_q    <= os_cnt_d;
            baud_tick_q <= baud_tick_d;
            uart_clk_q  <= uart_clk_d;
        end
    end

    assign os_tick   = os_tick_int;
    assign baud_tick = baud_tick_q;
    assign UART_clk  = uart_clk_q;

endmodule
